// File: rtl/mask_index_sequencer_if.sv
// -----------------------------------------------------------------------------
// mask_index_sequencer_if
//   Handshake bundle between a mask producer/index consumer and the
//   mask_index_sequencer.
//
//   Signals (named from the sequencer's point of view):
//     start_i      capture mask_i and begin a run (honoured only when idle)
//     mask_i       DATA_WIDTH-bit element mask to enumerate
//     busy_o       run in progress (emitting or signalling completion)
//     idx_valid_o  idx_o carries a valid element index
//     idx_ready_i  consumer accepts idx_o this cycle
//     idx_o        index of the lowest remaining set bit
//     idx_last_o   current index is the final one (qualified by idx_valid_o)
//     done_o       one-cycle completion pulse
//     total_o      indices handed off since the last accepted start
//     flush_i      abort the current run (only with MASK_SEQ_FLUSH_EN)
//
//   Modports: slave = sequencer, master = producer/consumer side.
//   Optional feature macro: MASK_SEQ_FLUSH_EN (adds flush_i).
// -----------------------------------------------------------------------------
interface mask_index_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_B      = $clog2(DATA_WIDTH)
) ();

  logic                  start_i;
  logic [DATA_WIDTH-1:0] mask_i;
  logic                  busy_o;
  logic                  idx_valid_o;
  logic                  idx_ready_i;
  logic [IDX_B-1:0]      idx_o;
  logic                  idx_last_o;
  logic                  done_o;
  logic [IDX_B:0]        total_o;
`ifdef MASK_SEQ_FLUSH_EN
  logic                  flush_i;
`endif

`ifdef MASK_SEQ_FLUSH_EN
  modport slave (
    input  start_i, mask_i, idx_ready_i, flush_i,
    output busy_o, idx_valid_o, idx_o, idx_last_o, done_o, total_o
  );

  modport master (
    output start_i, mask_i, idx_ready_i, flush_i,
    input  busy_o, idx_valid_o, idx_o, idx_last_o, done_o, total_o
  );
`else
  modport slave (
    input  start_i, mask_i, idx_ready_i,
    output busy_o, idx_valid_o, idx_o, idx_last_o, done_o, total_o
  );

  modport master (
    output start_i, mask_i, idx_ready_i,
    input  busy_o, idx_valid_o, idx_o, idx_last_o, done_o, total_o
  );
`endif

endinterface

// File: rtl/mask_index_sequencer.sv
// -----------------------------------------------------------------------------
// mask_index_sequencer
//   Captures a DATA_WIDTH-bit element mask and hands out the index of every
//   set bit, lowest first, one per valid/ready handshake. A running total of
//   handed-off indices lets the consumer cross-check against a popcount.
//
//   Ports:
//     clk_i  clock, rising edge
//     rst_i  asynchronous reset, active-high
//     bus    mask_index_sequencer_if.slave (start/mask in, index stream out,
//            busy/done/total status)
//
//   States: IDLE -> EMIT (non-empty mask) or DONE (empty mask);
//           EMIT -> DONE after the last handshake; DONE -> IDLE.
//
//   Optional feature macro: MASK_SEQ_FLUSH_EN
//     When defined, bus.flush_i aborts a run in EMIT or DONE: the block returns
//     to IDLE with remaining cleared and no done pulse; a transfer in the same
//     cycle is still counted.
// -----------------------------------------------------------------------------
module mask_index_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_B      = $clog2(DATA_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  mask_index_sequencer_if.slave     bus
);

  // One extra bit so an all-ones mask counts to DATA_WIDTH without wrapping.
  localparam int CNT_W = IDX_B + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0]      total_q, total_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic [IDX_B-1:0]      low_idx;
  logic                  single_bit;
  logic                  xfer;
  logic                  flush;

`ifdef MASK_SEQ_FLUSH_EN
  assign flush = bus.flush_i;
`else
  assign flush = 1'b0;
`endif

  // Priority encoder: scanning from the top down lets the lowest set bit win.
  always_comb begin
    low_idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (remaining_q[i]) begin
        low_idx = IDX_B'(i);
      end
    end
  end

  // x & (x-1) clears the lowest set bit; zero result means at most one bit.
  assign single_bit = (remaining_q != '0) &&
                      ((remaining_q & (remaining_q - DATA_WIDTH'(1))) == '0);

  assign xfer = valid_q && bus.idx_ready_i;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d     = state_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          remaining_d = bus.mask_i;
          total_d     = '0;
          busy_d      = 1'b1;
          if (bus.mask_i != '0) begin
            state_d = S_EMIT;
            valid_d = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_EMIT: begin
        if (xfer) begin
          remaining_d = remaining_q & (remaining_q - DATA_WIDTH'(1));
          total_d     = total_q + CNT_W'(1);
          if (single_bit) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end

      default: begin
        state_d     = S_IDLE;
        remaining_d = '0;
        busy_d      = 1'b0;
        valid_d     = 1'b0;
      end
    endcase

    // Abort overrides completion, but the count from a coinciding transfer
    // computed above is kept.
    if (flush && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      remaining_d = '0;
      busy_d      = 1'b0;
      valid_d     = 1'b0;
      done_d      = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      total_q     <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.idx_valid_o = valid_q;
  assign bus.idx_o       = low_idx;
  assign bus.idx_last_o  = valid_q && single_bit;
  assign bus.done_o      = done_q;
  assign bus.total_o     = total_q;

endmodule

// File: tb/tb_mask_index_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mask_index_sequencer
//   Directed bench for mask_index_sequencer. A queue-based reference model
//   (list of pending indices, emitting/done flags, running total) predicts the
//   outputs; a negedge process compares them every cycle, and each scenario
//   also pins the model with hand-computed literal expectations.
//   Build with +define+MASK_SEQ_FLUSH_EN to exercise the flush feature.
// -----------------------------------------------------------------------------
module tb_mask_index_sequencer;

  localparam int DW    = 32;
  localparam int IDX_B = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mask_index_sequencer_if #(.DATA_WIDTH(DW), .IDX_B(IDX_B)) bus ();

  mask_index_sequencer #(.DATA_WIDTH(DW), .IDX_B(IDX_B)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_q[$];
  bit  m_emit;
  bit  m_done;
  int  m_total;
  bit  m_was_busy;

  int  act_log[$];
  int  cyc;
  bit  done_seen;
  int  done_cyc;
  int  busy_cnt;
  bit  chk_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_emit  = 1'b0;
      m_done  = 1'b0;
      m_total = 0;
    end else begin
      cyc++;
      if (bus.idx_valid_o && bus.idx_ready_i) act_log.push_back(int'(bus.idx_o));
      m_was_busy = m_emit || m_done;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_emit) begin
        if (bus.idx_ready_i) begin
          void'(m_q.pop_front());
          m_total++;
          if (m_q.size() == 0) begin
            m_emit = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (bus.start_i) begin
        m_q.delete();
        for (int i = 0; i < DW; i++) if (bus.mask_i[i]) m_q.push_back(i);
        m_total = 0;
        if (m_q.size() == 0) m_done = 1'b1;
        else                 m_emit = 1'b1;
      end
`ifdef MASK_SEQ_FLUSH_EN
      if (bus.flush_i && m_was_busy) begin
        m_q.delete();
        m_emit = 1'b0;
        m_done = 1'b0;
      end
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("busy",  32'(bus.busy_o),      32'(m_emit || m_done));
      check("valid", 32'(bus.idx_valid_o), 32'(m_emit));
      check("done",  32'(bus.done_o),      32'(m_done));
      check("total", 32'(bus.total_o),     m_total);
      if (m_emit) begin
        check("idx",  32'(bus.idx_o),      m_q[0]);
        check("last", 32'(bus.idx_last_o), 32'(m_q.size() == 1));
      end
      if (bus.done_o && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (bus.busy_o) busy_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    act_log.delete();
    done_seen = 1'b0;
    busy_cnt  = 0;
  endtask

  task automatic start_run(input logic [31:0] m, output int t0);
    tick();
    clear_obs();
    bus.mask_i  = m;
    bus.start_i = 1'b1;
    t0 = cyc;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    check({name, " done_seen"}, 32'(done_seen), 32'd1);
  endtask

  task automatic check_log(input string name, input int exp[$]);
    check({name, " count"}, act_log.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s idx[%0d]", name, i),
            (i < act_log.size()) ? act_log[i] : -1, exp[i]);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, " busy"},  32'(bus.busy_o),      32'd0);
    check({name, " valid"}, 32'(bus.idx_valid_o), 32'd0);
    check({name, " last"},  32'(bus.idx_last_o),  32'd0);
    check({name, " done"},  32'(bus.done_o),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int t0;
    int n;
    int exp_full[$];

    rst             = 1'b1;
    chk_en          = 1'b0;
    cyc             = 0;
    bus.start_i     = 1'b0;
    bus.mask_i      = '0;
    bus.idx_ready_i = 1'b0;
`ifdef MASK_SEQ_FLUSH_EN
    bus.flush_i     = 1'b0;
`endif
    clear_obs();

    // Reset state
    #12;
    check_quiet("reset");
    check("reset total", 32'(bus.total_o), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Four sparse bits, consumer always ready
    bus.idx_ready_i = 1'b1;
    start_run(32'h0000_8421, t0);
    wait_done("sparse", 20);
    check_log("sparse", '{0, 5, 10, 15});
    check("sparse done latency", done_cyc - t0, 5);
    check("sparse total", 32'(bus.total_o), 32'd4);

    // Empty mask
    start_run(32'h0000_0000, t0);
    wait_done("empty", 10);
    check("empty done latency", done_cyc - t0, 1);
    check("empty total", 32'(bus.total_o), 32'd0);
    check("empty busy cycles", busy_cnt, 1);
    check("empty count", act_log.size(), 0);

    // Full mask with ready toggling every cycle
    start_run(32'hFFFF_FFFF, t0);
    n = 0;
    while (!done_seen && n < 200) begin
      tick();
      bus.idx_ready_i = ~bus.idx_ready_i;
      n++;
    end
    check("full done_seen", 32'(done_seen), 32'd1);
    for (int i = 0; i < DW; i++) exp_full.push_back(i);
    check_log("full", exp_full);
    check("full total", 32'(bus.total_o), 32'd32);
    bus.idx_ready_i = 1'b1;

    // Start held high and mask changed mid-run: no effect until IDLE
    tick();
    clear_obs();
    bus.mask_i  = 32'h8000_0001;
    bus.start_i = 1'b1;
    tick();
    bus.mask_i  = 32'hFFFF_FFFF;
    n = 0;
    while (!done_seen && n < 20) begin
      tick();
      n++;
    end
    bus.start_i = 1'b0;
    check("hold done_seen", 32'(done_seen), 32'd1);
    check_log("hold", '{0, 31});
    check("hold total", 32'(bus.total_o), 32'd2);
    tick();
    tick();
    check("hold no restart busy", 32'(bus.busy_o), 32'd0);

    // Asynchronous reset mid-run after index 5 accepted
    start_run(32'h0000_00F0, t0);
    n = 0;
    while (act_log.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    check("abort progress", act_log.size(), 2);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("abort");
    check("abort total", 32'(bus.total_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check("abort no done", 32'(done_seen), 32'd0);
    start_run(32'h0000_0002, t0);
    wait_done("post-abort", 10);
    check_log("post-abort", '{1});
    check("post-abort total", 32'(bus.total_o), 32'd1);

`ifdef MASK_SEQ_FLUSH_EN
    // Flush coinciding with the handshake of index 9
    start_run(32'h0000_0F00, t0);
    n = 0;
    while (act_log.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    check("flush pre idx", 32'(bus.idx_o), 32'd9);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("flush busy", 32'(bus.busy_o), 32'd0);
    check("flush total", 32'(bus.total_o), 32'd2);
    tick();
    tick();
    tick();
    check("flush no done", 32'(done_seen), 32'd0);
    check_log("flush", '{8, 9});
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mask_index_sequencer.md
Name: mask_index_sequencer

Overview:
Serial consumer of an element mask: captures a DATA_WIDTH-bit mask and emits the index of every set bit, lowest first, one per handshake over a valid/ready stream. It is the reading end of the set-bit population path. The bit counter reports how many elements are active, and this block tells the lane sequencer which elements they are, for compress, gather and masked-issue loops. A running total is provided so the consumer can cross-check against the popcount.

Parameters:
DATA_WIDTH  32  mask width in bits
IDX_B  $clog2(DATA_WIDTH)  index width; count width is IDX_B+1

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
start_i  input  1  capture mask_i and begin; honoured only in IDLE
mask_i  input  DATA_WIDTH  mask to enumerate; sampled on accepted start
busy_o  output  1  high in EMIT and DONE
idx_valid_o  output  1  idx_o holds a valid index
idx_ready_i  input  1  consumer accepts idx_o this cycle
idx_o  output  IDX_B  index of lowest remaining set bit
idx_last_o  output  1  current index is the final one; qualified by idx_valid_o
done_o  output  1  one-cycle pulse after the final handshake, or after an empty mask
total_o  output  IDX_B+1  indices handed off since the last accepted start

Behaviour:
- Reset (asynchronous, any state): state=IDLE, remaining register=0, total_o=0. busy_o, idx_valid_o, idx_last_o and done_o are all 0.
- States: IDLE, EMIT, DONE.
- IDLE, start_i=1:
  - remaining<=mask_i; total_o<=0.
  - Next state is EMIT if mask_i!=0, else DONE.
- IDLE, start_i=0: hold. total_o keeps the last run's value.
- EMIT:
  - idx_valid_o=1.
  - idx_o = priority encode (lowest set bit) of remaining, combinational from the register.
  - idx_last_o = 1 when remaining has exactly one bit set.
- Handshake: a transfer occurs when idx_valid_o && idx_ready_i.
  - On transfer: clear bit idx_o in remaining; total_o<=total_o+1.
  - If idx_last_o, go to DONE.
  - No transfer: idx_o and idx_last_o stay stable (valid must not drop and index must not change while waiting).
- DONE:
  - done_o=1 for exactly one cycle, idx_valid_o=0, then IDLE.
  - total_o equals popcount(mask) and stays valid until the next accepted start.
- Latency and throughput:
  - First idx_valid_o is 1 cycle after start is accepted.
  - 1 index per cycle with idx_ready_i held high.
  - An N-bit mask gives done_o N+1 cycles after start; an empty mask gives done_o at 1 cycle.
- start_i is ignored while busy_o=1; mask_i changes during a run have no effect.
- start_i in the same cycle done_o is high is ignored (state is DONE). Start is accepted the following cycle at the earliest.
- Full mask (all ones): indices 0..DATA_WIDTH-1, total_o=DATA_WIDTH; the IDX_B+1 width must not overflow.
- Reset asserted mid-run aborts immediately, with no done_o.

Optional Feature:
MASK_SEQ_FLUSH_EN
- Defined: adds input flush_i (1 bit).
  - flush_i=1 in EMIT or DONE sends the block to IDLE next cycle and clears remaining; done_o is not pulsed.
  - total_o retains the count of transfers completed before the flush.
  - A transfer coinciding with flush is counted.
  - flush_i has no effect in IDLE, and start_i in the same cycle as flush_i in IDLE is accepted.
- Undefined: no flush_i port; runs end only by completion or reset.

Test Plan:
- mask_i=32'h0000_8421, start pulse, idx_ready_i=1 -> idx_o 0,5,10,15 on consecutive cycles; idx_last_o only with 15; done_o on cycle 5 after start; total_o=4.
- mask_i=0 start -> no idx_valid_o; done_o pulse 1 cycle after start; total_o=0; busy_o high exactly 1 cycle.
- mask_i=32'hFFFF_FFFF, ready toggling 1/0 each cycle -> 32 indices 0..31 in order, each stable while ready=0; total_o=32 (6'b100000); done_o after final handshake.
- mask_i=32'h8000_0001 run with start_i held high and mask_i changed to 32'hFFFF_FFFF mid-run -> only indices 0 and 31 emitted; no restart until IDLE.
- mask_i=32'h0000_00F0, rst_i pulsed after index 5 accepted -> all outputs 0 asynchronously; new start with mask 32'h2 yields index 1, total_o=1.
- MASK_SEQ_FLUSH_EN defined: mask 32'h0000_0F00, flush_i with the handshake of index 9 -> IDLE next cycle, no done_o, total_o=2.
